// File: rtl/lane_ldst_arbiter_if.sv
// Handshake bundle between the lane array / memory port and the load/store
// arbiter. The arbiter side uses the slave modport; the lane/port side
// (or a bench) uses the master modport.
interface lane_ldst_arbiter_if #(
  parameter int NUM_LANES   = 16,
  parameter int WIDTH_LEN   = 8,
  parameter int WIDTH_LANES = $clog2(NUM_LANES)
);
  logic [NUM_LANES-1:0]           I_Req;
  logic [NUM_LANES-1:0]           I_St;
  logic [NUM_LANES*WIDTH_LEN-1:0] I_Len;
  logic                           I_Stall;
  logic                           I_Mem_Ready;
  logic                           O_Mem_Req;
  logic                           O_Mem_St;
  logic [WIDTH_LEN-1:0]           O_Beat;
  logic [NUM_LANES-1:0]           O_Grant;
  logic [WIDTH_LANES-1:0]         O_Sel;
  logic [NUM_LANES-1:0]           O_Done;
  logic                           O_Busy;

  modport slave (
    input  I_Req, I_St, I_Len, I_Stall, I_Mem_Ready,
    output O_Mem_Req, O_Mem_St, O_Beat, O_Grant, O_Sel, O_Done, O_Busy
  );

  modport master (
    output I_Req, I_St, I_Len, I_Stall, I_Mem_Ready,
    input  O_Mem_Req, O_Mem_St, O_Beat, O_Grant, O_Sel, O_Done, O_Busy
  );
endinterface

// File: rtl/lane_ldst_arbiter.sv
// Round-robin arbiter sharing one vector load/store memory port among the
// lane units. One burst owns the port at a time; the FSM counts beats and
// pulses a per-lane done into the lane commit path. Data muxing lives
// outside and follows O_Sel.
module lane_ldst_arbiter #(
  parameter int NUM_LANES   = 16,
  parameter int WIDTH_LANES = $clog2(NUM_LANES),
  parameter int WIDTH_LEN   = 8
) (
  input logic                clock,
  input logic                reset,
  lane_ldst_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH_LEN-1:0] LEN_ZERO = {WIDTH_LEN{1'b0}};
  localparam logic [WIDTH_LEN-1:0] LEN_ONE  = {{(WIDTH_LEN-1){1'b0}}, 1'b1};
  localparam logic [NUM_LANES-1:0] LANE_ONE = {{(NUM_LANES-1){1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic [WIDTH_LANES-1:0] lane_q,  lane_d;
  logic                   st_q,    st_d;
  logic [WIDTH_LEN-1:0]   len_q,   len_d;
  logic [WIDTH_LEN-1:0]   cnt_q,   cnt_d;
  logic [WIDTH_LANES-1:0] ptr_q,   ptr_d;

  logic                   pick_found_s;
  logic [WIDTH_LANES-1:0] pick_idx_s;
  logic                   beat_done_s;

  // Lane index base+off modulo NUM_LANES (off is always below NUM_LANES).
  function automatic logic [WIDTH_LANES-1:0] wrap_idx(
    input logic [WIDTH_LANES-1:0] base,
    input int                     off
  );
    int j;
    j = int'(base) + off;
    if (j >= NUM_LANES) begin
      j = j - NUM_LANES;
    end else begin
      j = j;
    end
    return j[WIDTH_LANES-1:0];
  endfunction

  // First requesting lane at or after the pointer, searching upward with wrap.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {WIDTH_LANES{1'b0}};
    for (int i = 32'sd0; i < NUM_LANES; i++) begin
      if (!pick_found_s && bus.I_Req[wrap_idx(ptr_q, i)]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = wrap_idx(ptr_q, i);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // A beat lands only while transferring, not stalled, and the port is ready.
  always_comb begin
    if (state_q == ST_XFER) begin
      beat_done_s = ~bus.I_Stall & bus.I_Mem_Ready;
    end else begin
      beat_done_s = 1'b0;
    end
  end

  // FSM next state: latch the winning burst, count beats, retire and advance the pointer.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    st_d    = st_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          lane_d = pick_idx_s;
          st_d   = bus.I_St[pick_idx_s];
          len_d  = bus.I_Len[pick_idx_s*WIDTH_LEN +: WIDTH_LEN];
          cnt_d  = LEN_ZERO;
          if (bus.I_Len[pick_idx_s*WIDTH_LEN +: WIDTH_LEN] == LEN_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (beat_done_s) begin
          cnt_d = cnt_q + LEN_ONE;
          if (cnt_q == (len_q - LEN_ONE)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_DONE: begin
        ptr_d   = wrap_idx(lane_q, 32'sd1);
        cnt_d   = LEN_ZERO;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = LEN_ZERO;
      end
    endcase
  end

  // State registers; active-low reset abandons any burst without a done pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lane_q  <= {WIDTH_LANES{1'b0}};
      st_q    <= 1'b0;
      len_q   <= LEN_ZERO;
      cnt_q   <= LEN_ZERO;
      ptr_q   <= {WIDTH_LANES{1'b0}};
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      st_q    <= st_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output decode from state registers; only O_Mem_Req also sees the live stall.
  always_comb begin
    bus.O_Grant   = {NUM_LANES{1'b0}};
    bus.O_Sel     = {WIDTH_LANES{1'b0}};
    bus.O_Mem_St  = 1'b0;
    bus.O_Mem_Req = 1'b0;
    bus.O_Beat    = LEN_ZERO;
    bus.O_Done    = {NUM_LANES{1'b0}};
    bus.O_Busy    = 1'b0;
    case (state_q)
      ST_XFER: begin
        bus.O_Grant   = LANE_ONE << lane_q;
        bus.O_Sel     = lane_q;
        bus.O_Mem_St  = st_q;
        bus.O_Mem_Req = ~bus.I_Stall;
        bus.O_Beat    = cnt_q;
        bus.O_Busy    = 1'b1;
      end
      ST_DONE: begin
        bus.O_Grant   = LANE_ONE << lane_q;
        bus.O_Sel     = lane_q;
        bus.O_Mem_St  = st_q;
        bus.O_Done    = LANE_ONE << lane_q;
        bus.O_Busy    = 1'b1;
      end
      default: begin
        bus.O_Busy    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lane_ldst_arbiter.sv
// Directed bench for lane_ldst_arbiter: one task per scenario, each with
// inline comparisons against hand-computed expectations.
module tb_lane_ldst_arbiter;
  localparam int N    = 16;
  localparam int WLEN = 8;
  localparam int WL   = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  lane_ldst_arbiter_if #(.NUM_LANES(N), .WIDTH_LEN(WLEN)) bus ();

  lane_ldst_arbiter #(.NUM_LANES(N), .WIDTH_LANES(WL), .WIDTH_LEN(WLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.I_Req       = '0;
    bus.I_St        = '0;
    bus.I_Len       = '0;
    bus.I_Stall     = 1'b0;
    bus.I_Mem_Ready = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.I_Req       = 16'($urandom);
      bus.I_St        = 16'($urandom);
      bus.I_Len       = {$urandom, $urandom, $urandom, $urandom};
      bus.I_Stall     = 1'($urandom);
      bus.I_Mem_Ready = 1'b1;
      tick();
    end
    checks++;
    if ({bus.O_Grant, bus.O_Sel, bus.O_Done} !== 36'h0)
      $display("FAIL reset_grant_sel_done: got grant=%h sel=%0d done=%h want all 0", bus.O_Grant, bus.O_Sel, bus.O_Done);
    else passed++;
    checks++;
    if ({bus.O_Mem_Req, bus.O_Mem_St, bus.O_Beat, bus.O_Busy} !== 11'h0)
      $display("FAIL reset_port: got req=%b st=%b beat=%0d busy=%b want all 0", bus.O_Mem_Req, bus.O_Mem_St, bus.O_Beat, bus.O_Busy);
    else passed++;
    clear_inputs();
    reset = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({bus.O_Busy, bus.O_Grant} !== 17'h0)
      $display("FAIL reset_release_idle: got busy=%b grant=%h want 0/0000", bus.O_Busy, bus.O_Grant);
    else passed++;
  endtask

  task automatic test_single_burst();
    apply_reset();
    bus.I_Len[3*WLEN +: WLEN] = 8'd4;
    bus.I_Req       = 16'h0008;
    bus.I_Mem_Ready = 1'b1;
    tick();
    bus.I_Len[3*WLEN +: WLEN] = 8'd1;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({bus.O_Grant, bus.O_Sel, bus.O_Mem_Req, bus.O_Mem_St, bus.O_Beat, bus.O_Done} !== {16'h0008, 4'd3, 1'b1, 1'b0, b[7:0], 16'h0000})
        $display("FAIL single_beat%0d: got grant=%h sel=%0d req=%b st=%b beat=%0d done=%h want 0008/3/1/0/%0d/0000",
                 b, bus.O_Grant, bus.O_Sel, bus.O_Mem_Req, bus.O_Mem_St, bus.O_Beat, bus.O_Done, b);
      else passed++;
      tick();
    end
    checks++;
    if ({bus.O_Done, bus.O_Grant, bus.O_Mem_Req} !== {16'h0008, 16'h0008, 1'b0})
      $display("FAIL single_done: got done=%h grant=%h req=%b want 0008/0008/0", bus.O_Done, bus.O_Grant, bus.O_Mem_Req);
    else passed++;
    bus.I_Req = 16'h0000;
    tick();
    checks++;
    if ({bus.O_Done, bus.O_Busy} !== 17'h0)
      $display("FAIL single_after_done: got done=%h busy=%b want 0000/0", bus.O_Done, bus.O_Busy);
    else passed++;
  endtask

  task automatic test_rr_wrap();
    int exp_lane [4];
    logic [N-1:0] exp_oh;
    exp_lane[0] = 0; exp_lane[1] = 15; exp_lane[2] = 0; exp_lane[3] = 15;
    apply_reset();
    for (int i = 0; i < N; i++) bus.I_Len[i*WLEN +: WLEN] = 8'd1;
    bus.I_Req       = 16'h8001;
    bus.I_Mem_Ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_oh = 16'h0001 << exp_lane[k];
      checks++;
      if ({bus.O_Grant, bus.O_Sel, bus.O_Mem_Req} !== {exp_oh, 4'(exp_lane[k]), 1'b1})
        $display("FAIL rr_grant%0d: got grant=%h sel=%0d req=%b want %h/%0d/1", k, bus.O_Grant, bus.O_Sel, bus.O_Mem_Req, exp_oh, exp_lane[k]);
      else passed++;
      tick();
      checks++;
      if (bus.O_Done !== exp_oh)
        $display("FAIL rr_done%0d: got done=%h want %h", k, bus.O_Done, exp_oh);
      else passed++;
      tick();
      checks++;
      if ({bus.O_Busy, bus.O_Grant} !== 17'h0)
        $display("FAIL rr_gap%0d: got busy=%b grant=%h want 0/0000", k, bus.O_Busy, bus.O_Grant);
      else passed++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    logic [5:0] rdy_v;
    logic [5:0] stl_v;
    int beats;
    int dones;
    rdy_v = 6'b110001;
    stl_v = 6'b001000;
    beats = 0;
    dones = 0;
    apply_reset();
    bus.I_Len[5*WLEN +: WLEN] = 8'd3;
    bus.I_St        = 16'h0020;
    bus.I_Req       = 16'h0020;
    bus.I_Mem_Ready = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      bus.I_Mem_Ready = rdy_v[c];
      bus.I_Stall     = stl_v[c];
      #1;
      checks++;
      if ({bus.O_Beat, bus.O_Mem_Req, bus.O_Mem_St, bus.O_Sel} !== {beats[7:0], ~stl_v[c], 1'b1, 4'd5})
        $display("FAIL stall_c%0d: got beat=%0d req=%b st=%b sel=%0d want %0d/%b/1/5", c, bus.O_Beat, bus.O_Mem_Req, bus.O_Mem_St, bus.O_Sel, beats, ~stl_v[c]);
      else passed++;
      if (rdy_v[c] && !stl_v[c]) beats++;
      @(posedge clock);
      #1;
    end
    bus.I_Stall     = 1'b0;
    bus.I_Mem_Ready = 1'b1;
    bus.I_Req       = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      if (bus.O_Done == 16'h0020) dones++;
      if (bus.O_Done != 16'h0000 && bus.O_Done != 16'h0020) dones += 100;
      tick();
    end
    checks++;
    if (dones !== 1)
      $display("FAIL stall_done_count: got %0d pulses want 1", dones);
    else passed++;
    checks++;
    if (beats !== 3)
      $display("FAIL stall_beat_count: got %0d beats want 3", beats);
    else passed++;
  endtask

  task automatic test_zero_len();
    apply_reset();
    bus.I_Req       = 16'h0080;
    bus.I_Mem_Ready = 1'b1;
    #1;
    checks++;
    if ({bus.O_Mem_Req, bus.O_Done} !== 17'h0)
      $display("FAIL zero_idle: got req=%b done=%h want 0/0000", bus.O_Mem_Req, bus.O_Done);
    else passed++;
    tick();
    checks++;
    if ({bus.O_Done, bus.O_Grant, bus.O_Mem_Req} !== {16'h0080, 16'h0080, 1'b0})
      $display("FAIL zero_done: got done=%h grant=%h req=%b want 0080/0080/0", bus.O_Done, bus.O_Grant, bus.O_Mem_Req);
    else passed++;
    bus.I_Req = 16'h0000;
    tick();
    checks++;
    if ({bus.O_Done, bus.O_Mem_Req, bus.O_Busy} !== 18'h0)
      $display("FAIL zero_after: got done=%h req=%b busy=%b want 0000/0/0", bus.O_Done, bus.O_Mem_Req, bus.O_Busy);
    else passed++;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus.I_Len[2*WLEN +: WLEN] = 8'd8;
    bus.I_Req       = 16'h0004;
    bus.I_Mem_Ready = 1'b1;
    tick();
    tick(); tick(); tick();
    checks++;
    if ({bus.O_Beat, bus.O_Grant} !== {8'd3, 16'h0004})
      $display("FAIL midrst_pre: got beat=%0d grant=%h want 3/0004", bus.O_Beat, bus.O_Grant);
    else passed++;
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.O_Grant, bus.O_Sel, bus.O_Mem_Req, bus.O_Mem_St, bus.O_Beat, bus.O_Done, bus.O_Busy} !== 47'h0)
      $display("FAIL midrst_outputs: got grant=%h sel=%0d req=%b beat=%0d done=%h busy=%b want all 0",
               bus.O_Grant, bus.O_Sel, bus.O_Mem_Req, bus.O_Beat, bus.O_Done, bus.O_Busy);
    else passed++;
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.O_Grant, bus.O_Beat, bus.O_Mem_Req, bus.O_Done} !== {16'h0004, 8'd0, 1'b1, 16'h0000})
      $display("FAIL midrst_restart: got grant=%h beat=%0d req=%b done=%h want 0004/0/1/0000", bus.O_Grant, bus.O_Beat, bus.O_Mem_Req, bus.O_Done);
    else passed++;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_burst();
    test_rr_wrap();
    test_stall();
    test_zero_len();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
